// File: rtl/deser_fifo.sv
// deser_fifo: framed serial receiver (start, DATA_WIDTH bits LSB first, stop)
// feeding a first-word-fall-through FIFO drained over a valid/ready interface.
module deser_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  serial_i,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_out_o,
    input  logic                  ready_in_i,
    output logic                  fifo_full_o,
    output logic                  fifo_empty_o,
    output logic                  frame_err_o,
    output logic                  overflow_o
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_reg;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic                   pop;
    logic                   push_req;
    logic                   push_ok;
    logic [PTR_W-1:0]       rd_ptr_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic [DATA_WIDTH-1:0]  head_nxt;

    // Receive FSM: frame reassembly, stop-bit check and stuck-low line guard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!serial_i) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    shift_reg[bit_cnt] <= serial_i;
                    bit_cnt            <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (serial_i) begin
                        state <= ST_IDLE;
                    end else begin
                        frame_err_o <= 1'b1;
                        state       <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (serial_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FIFO control: push acceptance, next pointers/count and next head word.
    always_comb begin
        pop        = valid_out_o && ready_in_i;
        push_req   = (state == ST_STOP) && serial_i;
        push_ok    = push_req && ((count < CNT_W'(FIFO_DEPTH)) || pop);
        rd_ptr_nxt = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        count_nxt  = count;
        if (push_ok && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_nxt = count - CNT_W'(1);
        end
        // The word being written this cycle becomes head only when it lands at rd_ptr_nxt.
        head_nxt = '0;
        if (count_nxt != '0) begin
            if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
                head_nxt = shift_reg;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Storage array; contents deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    // FIFO state and registered status/data outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            parallel_out_o <= '0;
            valid_out_o    <= 1'b0;
            fifo_empty_o   <= 1'b1;
            fifo_full_o    <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr         <= rd_ptr_nxt;
            count          <= count_nxt;
            parallel_out_o <= head_nxt;
            valid_out_o    <= (count_nxt != '0);
            fifo_empty_o   <= (count_nxt == '0);
            fifo_full_o    <= (count_nxt == CNT_W'(FIFO_DEPTH));
            overflow_o     <= push_req && !push_ok;
        end
    end

endmodule

// File: tb/tb_deser_fifo.sv
// tb_deser_fifo: directed vectors for deser_fifo with hand-computed expectations.
module tb_deser_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial;
    logic [7:0] parallel_out;
    logic       valid_out;
    logic       ready_in;
    logic       fifo_full;
    logic       fifo_empty;
    logic       frame_err;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;

    deser_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .serial_i       (serial),
        .parallel_out_o (parallel_out),
        .valid_out_o    (valid_out),
        .ready_in_i     (ready_in),
        .fifo_full_o    (fifo_full),
        .fifo_empty_o   (fifo_empty),
        .frame_err_o    (frame_err),
        .overflow_o     (overflow)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle error/overflow strobes.
    always @(posedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
        if (overflow)  ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial = b;
        tick();
    endtask

    task automatic send_data(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_data(d);
        send_bit(stop);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(parallel_out), 32'h0);
        check({tag, "_valid"}, 32'(valid_out),    32'h0);
        check({tag, "_empty"}, 32'(fifo_empty),   32'h1);
        check({tag, "_full"},  32'(fifo_full),    32'h0);
        check({tag, "_ferr"},  32'(frame_err),    32'h0);
        check({tag, "_ovf"},   32'(overflow),     32'h0);
    endtask

    initial begin
        logic [7:0] vec;
        rst      = 1'b1;
        serial   = 1'b1;
        ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("rst");

        // Single frame 0xA5 with consumer ready.
        ready_in = 1'b1;
        vec = 8'hA5;
        send_data(vec);
        check("t1_valid_before_stop", 32'(valid_out), 32'h0);
        send_bit(1'b1);
        check("t1_valid", 32'(valid_out), 32'h1);
        check("t1_data",  32'(parallel_out), 32'hA5);
        send_bit(1'b1);
        check("t1_valid_drop", 32'(valid_out), 32'h0);
        check("t1_empty",      32'(fifo_empty), 32'h1);
        check("t1_data_zero",  32'(parallel_out), 32'h0);

        // Back-to-back frames, consumer stalled then released.
        ready_in = 1'b0;
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'hFF, 1'b1);
        serial = 1'b1;
        check("t2_empty", 32'(fifo_empty), 32'h0);
        check("t2_full",  32'(fifo_full),  32'h0);
        tick();
        check("t2_hold", 32'(parallel_out), 32'h01);
        ready_in = 1'b1;
        check("t2_w0", 32'(parallel_out), 32'h01);
        tick();
        check("t2_w1", 32'(parallel_out), 32'h80);
        tick();
        check("t2_w2", 32'(parallel_out), 32'hFF);
        tick();
        check("t2_empty_end", 32'(fifo_empty), 32'h1);

        // Fill to capacity, then one frame that must be dropped.
        ready_in = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        check("t3_full",    32'(fifo_full), 32'h1);
        check("t3_no_ovf",  32'(overflow),  32'h0);
        send_frame(8'h10, 1'b1);
        check("t3_ovf",     32'(overflow),  32'h1);
        serial = 1'b1;
        tick();
        check("t3_ovf_once", 32'(overflow), 32'h0);
        check("t3_ovf_cnt",  32'(ovf_cnt),  32'h1);
        check("t3_head",     32'(parallel_out), 32'h00);

        // Full FIFO: push of 0x55 coincides with a pop on the stop-bit cycle.
        send_data(8'h55);
        ready_in = 1'b1;
        send_bit(1'b1);
        check("t4_no_ovf", 32'(overflow),  32'h0);
        check("t4_full",   32'(fifo_full), 32'h1);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t4_w%0d", i), 32'(parallel_out), 32'(i));
            tick();
            if (i == 1) check("t4_full_drop", 32'(fifo_full), 32'h0);
        end
        check("t4_last",   32'(parallel_out), 32'h55);
        tick();
        check("t4_empty",  32'(fifo_empty), 32'h1);
        check("t4_ovf_cnt", 32'(ovf_cnt), 32'h1);

        // Framing error with a held-low line, then a clean frame.
        ready_in = 1'b0;
        send_frame(8'h3C, 1'b0);
        check("t5_ferr",  32'(frame_err), 32'h1);
        check("t5_valid", 32'(valid_out), 32'h0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("t5_ferr_once", 32'(frame_err), 32'h0);
        check("t5_valid_brk", 32'(valid_out), 32'h0);
        send_bit(1'b1);
        send_frame(8'hC3, 1'b1);
        check("t5_valid_c3", 32'(valid_out), 32'h1);
        check("t5_data_c3",  32'(parallel_out), 32'hC3);
        check("t5_ferr_cnt", 32'(err_cnt), 32'h1);
        serial   = 1'b1;
        ready_in = 1'b1;
        tick();
        check("t5_empty", 32'(fifo_empty), 32'h1);

        // Reset mid-frame with two words buffered.
        ready_in = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        vec = 8'h99;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(vec[i]);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        tick();
        rst    = 1'b0;
        serial = 1'b1;
        tick();
        check_reset_outputs("t6_post");
        send_frame(8'h77, 1'b1);
        serial = 1'b1;
        check("t6_valid", 32'(valid_out), 32'h1);
        check("t6_data",  32'(parallel_out), 32'h77);
        ready_in = 1'b1;
        tick();
        check("t6_empty", 32'(fifo_empty), 32'h1);
        check("t6_data0", 32'(parallel_out), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/deser_fifo.md
# deser_fifo

Receive-side counterpart of the parallel-to-serial SERDES path. Samples a single-bit framed serial line at one bit per clock, reassembles each frame into a DATA_WIDTH-bit word, and buffers words in an internal first-word-fall-through FIFO. The FIFO is drained through a valid/ready parallel interface. The block sits at the far end of the serial link and feeds the downstream parallel consumer.

## Interface
- DATA_WIDTH, 8: payload bits per frame and parallel word width.
- FIFO_DEPTH, 16: word capacity. Must be a power of two and ≥2.

- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- serial_i  input  1  serial line; idles high.
- parallel_out_o  output  DATA_WIDTH  FIFO head word; reads 0 when the FIFO is empty.
- valid_out_o  output  1  head word is valid; equals !fifo_empty_o.
- ready_in_i  input  1  consumer accepts the head word.
- fifo_full_o  output  1  count == FIFO_DEPTH.
- fifo_empty_o  output  1  count == 0.
- frame_err_o  output  1  one-cycle pulse when a frame has a bad stop bit.
- overflow_o  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

## Operation
- Frame format: one start bit (0), then DATA_WIDTH data bits LSB first, then one stop bit (1). One bit per clock, with no oversampling.
- Receive FSM states:
  - IDLE: stay while serial_i=1. On serial_i=0, go to DATA with bit_cnt=0.
  - DATA: shift_reg[bit_cnt] <= serial_i, then bit_cnt++. When bit_cnt==DATA_WIDTH-1, go to STOP.
  - STOP: if serial_i=1, attempt a push of shift_reg and go to IDLE. If serial_i=0, pulse frame_err_o, drop the word, and go to BREAK.
  - BREAK: stay while serial_i=0. On serial_i=1, go to IDLE. This prevents a stuck-low line from being decoded as repeated frames.
- Back-to-back frames are supported: a start bit in the cycle after the stop bit is detected.
- bit_cnt width is $clog2(DATA_WIDTH). count width is $clog2(FIFO_DEPTH)+1. Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally at FIFO_DEPTH.
- pop = valid_out_o && ready_in_i.
- Push acceptance: the push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the word is dropped and overflow_o pulses.
- Simultaneous push and pop: count is unchanged and both pointers advance. This applies even when the FIFO is full or when count==1.
- A frame error never writes the FIFO and never asserts overflow_o.
- parallel_out_o = mem[rd_ptr] when not empty, else 0.

## Timing
- Reset (asynchronous assert, synchronous release) leaves:
  - FSM in IDLE, bit_cnt=0, shift_reg=0;
  - pointers and count at 0;
  - parallel_out_o=0, valid_out_o=0, fifo_empty_o=1, fifo_full_o=0, frame_err_o=0, overflow_o=0.
- Memory contents are not reset.
- Reset asserted mid-frame or mid-drain discards the partial frame and all buffered words. After release the receiver waits in IDLE for a start bit.
- Frame length is DATA_WIDTH+2 cycles. If the stop bit is sampled in cycle N, the word is written at the end of N. valid_out_o and the word appear in cycle N+1. End-to-end latency from start bit to valid_out_o is DATA_WIDTH+2 cycles.
- frame_err_o and overflow_o are registered. Each is high in cycle N+1 for exactly one cycle.
- The pop takes effect at the clock edge where valid_out_o && ready_in_i. The next word, or empty, is visible the following cycle.
- Handshake rule: parallel_out_o must hold stable while valid_out_o=1 and ready_in_i=0.
- fifo_full_o and fifo_empty_o are registered and derived from count; they update in the cycle after the push or pop.

## Test plan
- Single frame, ready_in_i=1: drive serial_i 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB first, stop). Required: valid_out_o rises 10 cycles after the start bit with parallel_out_o=0xA5, then drops 1 cycle later; fifo_empty_o returns to 1.
- Back-to-back: 0x01, 0x80, 0xFF with no idle gap, ready_in_i=0. Required: count 3, fifo_empty_o=0. Raising ready_in_i yields 0x01, 0x80, 0xFF on three consecutive cycles.
- Overflow: 17 frames 0x00..0x10 with ready_in_i=0. Required: fifo_full_o=1 after frame 16; frame 17 pulses overflow_o once. Drain yields 0x00..0x0F in order.
- Full plus simultaneous pop: with the FIFO full, hold ready_in_i=1 during frame 0x55. Required: no overflow_o; 0x55 is the last word drained; fifo_full_o stays 1 until draining starts outpacing pushes.
- Framing error: send 0x3C with stop bit 0, hold serial_i low 5 cycles, then high, then a valid 0xC3 frame. Required: one frame_err_o pulse, no write for 0x3C, and only 0xC3 delivered.
- Reset mid-frame: assert rst_i after 4 data bits of a frame, with 2 words already buffered. Required: all outputs at reset values immediately; the next full frame 0x77 is received correctly and is the only word delivered.
